// File: rtl/glb_access_responder.sv
// GLB-side responder: arbitrates token-engine read/write requests onto a single-port
// SRAM macro, range-checks addresses and returns read data with a valid strobe.
module glb_access_responder #(
    parameter int ADDR_W        = 14,
    parameter int SRAM_LAT      = 1,
    parameter int MAX_WR_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              glb_read_req,
    input  logic [31:0]       glb_read_addr,
    input  logic              glb_write_req,
    input  logic [31:0]       glb_write_addr,
    input  logic [3:0]        glb_write_web,
    input  logic [31:0]       glb_write_data,
    output logic              rd_gnt_o,
    output logic              wr_gnt_o,
    output logic [31:0]       glb_read_data_o,
    output logic              rd_valid_o,
    output logic              addr_err_o,
    output logic              sram_cs_o,
    output logic [3:0]        sram_web_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i
);

    localparam int STREAK_W = $clog2(MAX_WR_STREAK + 1);

    typedef enum logic {
        LAST_RD,
        LAST_WR
    } arb_state_t;

    arb_state_t          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                streak_at_max;
    logic                rd_gnt, wr_gnt;
    logic                rd_bad, wr_bad;
    logic [SRAM_LAT:0]   tag_v, tag_e;

    // Misaligned, or any bit set above the GLB word-address window.
    assign rd_bad = (glb_read_addr[1:0] != 2'b00) || ((glb_read_addr >> (ADDR_W + 2)) != 32'h0);
    assign wr_bad = (glb_write_addr[1:0] != 2'b00) || ((glb_write_addr >> (ADDR_W + 2)) != 32'h0);

    assign streak_at_max = (streak_q == STREAK_W'(MAX_WR_STREAK));

    always_comb begin
        rd_gnt   = 1'b0;
        wr_gnt   = 1'b0;
        state_d  = state_q;
        streak_d = streak_q;
        if (rst_n) begin
            if (glb_write_req && !(glb_read_req && streak_at_max)) begin
                wr_gnt = 1'b1;
            end else if (glb_read_req) begin
                rd_gnt = 1'b1;
            end

            if (rd_gnt) begin
                state_d = LAST_RD;
            end else if (wr_gnt) begin
                state_d = LAST_WR;
            end

            if (rd_gnt || !glb_read_req) begin
                streak_d = '0;
            end else if (wr_gnt && !streak_at_max) begin
                streak_d = streak_q + STREAK_W'(1);
            end
        end
    end

    assign rd_gnt_o = rd_gnt;
    assign wr_gnt_o = wr_gnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= LAST_RD;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // Command stage: one SRAM command per grant, driven the cycle after the grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sram_cs_o    <= 1'b0;
            sram_web_o   <= '1;
            sram_addr_o  <= '0;
            sram_wdata_o <= '0;
        end else begin
            sram_cs_o  <= (wr_gnt && !wr_bad) || (rd_gnt && !rd_bad);
            sram_web_o <= '1;
            if (wr_gnt) begin
                sram_addr_o  <= glb_write_addr[ADDR_W+1:2];
                sram_wdata_o <= glb_write_data;
                if (!wr_bad) begin
                    sram_web_o <= glb_write_web;
                end
            end else if (rd_gnt) begin
                sram_addr_o <= glb_read_addr[ADDR_W+1:2];
            end
        end
    end

    // Read-tag pipe: stage k is live in cycle T+1+k; the last stage samples the SRAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_v           <= '0;
            tag_e           <= '0;
            rd_valid_o      <= 1'b0;
            glb_read_data_o <= '0;
            addr_err_o      <= 1'b0;
        end else begin
            tag_v      <= {tag_v[SRAM_LAT-1:0], rd_gnt};
            tag_e      <= {tag_e[SRAM_LAT-1:0], rd_gnt && rd_bad};
            rd_valid_o <= tag_v[SRAM_LAT];
            if (tag_v[SRAM_LAT]) begin
                glb_read_data_o <= tag_e[SRAM_LAT] ? 32'h0 : sram_rdata_i;
            end
            if ((wr_gnt && wr_bad) || (rd_gnt && rd_bad)) begin
                addr_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_glb_access_responder.sv
// Scoreboard bench for glb_access_responder: reference memory predicts read data and
// return cycle per read grant; directed sequences check grants, commands and errors.
module tb_glb_access_responder;

    localparam int ADDR_W        = 14;
    localparam int SRAM_LAT      = 1;
    localparam int MAX_WR_STREAK = 4;
    localparam int DEPTH         = 2 ** ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              glb_read_req;
    logic [31:0]       glb_read_addr;
    logic              glb_write_req;
    logic [31:0]       glb_write_addr;
    logic [3:0]        glb_write_web;
    logic [31:0]       glb_write_data;
    logic              rd_gnt_o;
    logic              wr_gnt_o;
    logic [31:0]       glb_read_data_o;
    logic              rd_valid_o;
    logic              addr_err_o;
    logic              sram_cs_o;
    logic [3:0]        sram_web_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [31:0]       sram_wdata_o;
    logic [31:0]       sram_rdata_i;

    glb_access_responder #(
        .ADDR_W(ADDR_W),
        .SRAM_LAT(SRAM_LAT),
        .MAX_WR_STREAK(MAX_WR_STREAK)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .glb_read_req(glb_read_req),
        .glb_read_addr(glb_read_addr),
        .glb_write_req(glb_write_req),
        .glb_write_addr(glb_write_addr),
        .glb_write_web(glb_write_web),
        .glb_write_data(glb_write_data),
        .rd_gnt_o(rd_gnt_o),
        .wr_gnt_o(wr_gnt_o),
        .glb_read_data_o(glb_read_data_o),
        .rd_valid_o(rd_valid_o),
        .addr_err_o(addr_err_o),
        .sram_cs_o(sram_cs_o),
        .sram_web_o(sram_web_o),
        .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o),
        .sram_rdata_i(sram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // SRAM macro model, 1-cycle read latency.
    logic [31:0] sram_mem [0:DEPTH-1];
    logic [31:0] ref_mem  [0:DEPTH-1];

    initial sram_rdata_i = 32'h0;
    always @(posedge clk) begin
        if (sram_cs_o) begin
            if (sram_web_o == 4'hF) begin
                sram_rdata_i <= sram_mem[sram_addr_o];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (!sram_web_o[b]) sram_mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
                end
            end
        end
    end

    function automatic bit bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'h0);
    endfunction

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    // Monitor: compare returns, then record new grants into the reference model.
    always @(negedge clk) begin
        if (rd_valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_rd_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_rd_data", glb_read_data_o, mon_e.data);
                check("sb_rd_latency", cyc, mon_e.due);
            end
        end
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (wr_gnt_o && !bad_addr(glb_write_addr)) begin
                for (int b = 0; b < 4; b++) begin
                    if (!glb_write_web[b])
                        ref_mem[glb_write_addr[ADDR_W+1:2]][b*8 +: 8] = glb_write_data[b*8 +: 8];
                end
            end
            if (rd_gnt_o) begin
                mon_e.data = bad_addr(glb_read_addr) ? 32'h0 : ref_mem[glb_read_addr[ADDR_W+1:2]];
                mon_e.due  = cyc + 2 + SRAM_LAT;
                sb_q.push_back(mon_e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Waits (bounded) for the grant, returns just after the edge that ends the grant cycle.
    task automatic wait_gnt(input bit is_wr);
        int n = 0;
        @(negedge clk);
        while (!(is_wr ? wr_gnt_o : rd_gnt_o) && n < 8) begin
            n++;
            @(negedge clk);
        end
        check(is_wr ? "wr_gnt_seen" : "rd_gnt_seen", {31'h0, is_wr ? wr_gnt_o : rd_gnt_o}, 32'd1);
        step();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        glb_write_req  = 1'b1;
        glb_write_addr = a;
        glb_write_data = d;
        glb_write_web  = w;
        wait_gnt(1'b1);
        glb_write_req = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        glb_read_req  = 1'b1;
        glb_read_addr = a;
        wait_gnt(1'b0);
        glb_read_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_rd_gnt"}, {31'h0, rd_gnt_o}, 32'd0);
        check({pfx, "_wr_gnt"}, {31'h0, wr_gnt_o}, 32'd0);
        check({pfx, "_rd_valid"}, {31'h0, rd_valid_o}, 32'd0);
        check({pfx, "_rd_data"}, glb_read_data_o, 32'h0);
        check({pfx, "_addr_err"}, {31'h0, addr_err_o}, 32'd0);
        check({pfx, "_cs"}, {31'h0, sram_cs_o}, 32'd0);
        check({pfx, "_web"}, {28'h0, sram_web_o}, 32'hF);
        check({pfx, "_addr"}, {18'h0, sram_addr_o}, 32'h0);
        check({pfx, "_wdata"}, sram_wdata_o, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i] = 32'h5A5A_0000 ^ i;
            ref_mem[i]  = 32'h5A5A_0000 ^ i;
        end
        sram_mem[16'h10] = 32'hDEAD_BEEF;
        ref_mem[16'h10]  = 32'hDEAD_BEEF;

        // Reset with both requests up: grants must stay low.
        rst_n          = 1'b0;
        glb_read_req   = 1'b1;
        glb_read_addr  = 32'h40;
        glb_write_req  = 1'b1;
        glb_write_addr = 32'h80;
        glb_write_web  = 4'h0;
        glb_write_data = 32'h1;
        repeat (2) @(posedge clk);
        samp();
        check_reset_outputs("rst");
        step();
        glb_read_req  = 1'b0;
        glb_write_req = 1'b0;
        rst_n         = 1'b1;

        // 1: single read, latency and command
        step();
        glb_read_req  = 1'b1;
        glb_read_addr = 32'h40;
        samp();
        check("t1_rd_gnt", {31'h0, rd_gnt_o}, 32'd1);
        check("t1_wr_gnt", {31'h0, wr_gnt_o}, 32'd0);
        step();
        glb_read_req = 1'b0;
        samp();
        check("t1_cs", {31'h0, sram_cs_o}, 32'd1);
        check("t1_addr", {18'h0, sram_addr_o}, 32'h10);
        check("t1_web", {28'h0, sram_web_o}, 32'hF);
        check("t1_valid_t1", {31'h0, rd_valid_o}, 32'd0);
        samp();
        check("t1_valid_t2", {31'h0, rd_valid_o}, 32'd0);
        samp();
        check("t1_valid_t3", {31'h0, rd_valid_o}, 32'd1);
        check("t1_data", glb_read_data_o, 32'hDEAD_BEEF);
        samp();
        check("t1_valid_t4", {31'h0, rd_valid_o}, 32'd0);
        check("t1_data_hold", glb_read_data_o, 32'hDEAD_BEEF);

        // 2: same-word read and write together, write first
        step();
        glb_write_req  = 1'b1;
        glb_write_addr = 32'h80;
        glb_write_data = 32'h1234_5678;
        glb_write_web  = 4'h0;
        glb_read_req   = 1'b1;
        glb_read_addr  = 32'h80;
        samp();
        check("t2_wr_first", {31'h0, wr_gnt_o}, 32'd1);
        check("t2_rd_wait", {31'h0, rd_gnt_o}, 32'd0);
        step();
        glb_write_req = 1'b0;
        samp();
        check("t2_rd_next", {31'h0, rd_gnt_o}, 32'd1);
        check("t2_wr_cs", {31'h0, sram_cs_o}, 32'd1);
        check("t2_wr_web", {28'h0, sram_web_o}, 32'h0);
        check("t2_wr_addr", {18'h0, sram_addr_o}, 32'h20);
        check("t2_wr_wdata", sram_wdata_o, 32'h1234_5678);
        step();
        glb_read_req = 1'b0;
        samp();
        samp();
        samp();
        check("t2_valid", {31'h0, rd_valid_o}, 32'd1);
        check("t2_data", glb_read_data_o, 32'h1234_5678);

        // 3: write streak limit with both held
        step();
        glb_write_req  = 1'b1;
        glb_write_addr = 32'h100;
        glb_write_data = 32'hCAFE_0000;
        glb_write_web  = 4'h0;
        glb_read_req   = 1'b1;
        glb_read_addr  = 32'h104;
        for (int i = 0; i < 15; i++) begin
            samp();
            check($sformatf("t3_wr_gnt[%0d]", i), {31'h0, wr_gnt_o}, (i % 5 != 4) ? 32'd1 : 32'd0);
            check($sformatf("t3_rd_gnt[%0d]", i), {31'h0, rd_gnt_o}, (i % 5 == 4) ? 32'd1 : 32'd0);
            step();
        end
        glb_write_req = 1'b0;
        glb_read_req  = 1'b0;

        // 4: byte-masked write, then all-masked write
        do_write(32'h200, 32'hAABB_CCDD, 4'h0);
        do_write(32'h200, 32'h1122_3344, 4'b1100);
        do_read(32'h200);
        samp();
        samp();
        samp();
        check("t4_valid", {31'h0, rd_valid_o}, 32'd1);
        check("t4_data", glb_read_data_o, 32'hAABB_3344);
        do_write(32'h200, 32'h0, 4'hF);
        samp();
        check("t4_webF_cs", {31'h0, sram_cs_o}, 32'd1);
        check("t4_webF_web", {28'h0, sram_web_o}, 32'hF);
        do_read(32'h200);
        samp();
        samp();
        samp();
        check("t4_webF_data", glb_read_data_o, 32'hAABB_3344);
        check("t4_no_err", {31'h0, addr_err_o}, 32'd0);

        // 5: address errors
        do_read(32'h2);
        samp();
        check("t5_mis_cs", {31'h0, sram_cs_o}, 32'd0);
        check("t5_mis_err", {31'h0, addr_err_o}, 32'd1);
        samp();
        samp();
        check("t5_mis_valid", {31'h0, rd_valid_o}, 32'd1);
        check("t5_mis_data", glb_read_data_o, 32'h0);
        do_read(32'h1 << (ADDR_W + 2));
        samp();
        check("t5_oor_cs", {31'h0, sram_cs_o}, 32'd0);
        samp();
        samp();
        check("t5_oor_valid", {31'h0, rd_valid_o}, 32'd1);
        check("t5_oor_data", glb_read_data_o, 32'h0);
        do_write(32'h201, 32'hFFFF_FFFF, 4'h0);
        samp();
        check("t5_wr_cs", {31'h0, sram_cs_o}, 32'd0);
        do_read(32'h200);
        samp();
        samp();
        samp();
        check("t5_untouched", glb_read_data_o, 32'hAABB_3344);
        check("t5_err_sticky", {31'h0, addr_err_o}, 32'd1);

        // 6: reset with reads in flight
        step();
        glb_read_req  = 1'b1;
        glb_read_addr = 32'h40;
        samp();
        check("t6_gnt0", {31'h0, rd_gnt_o}, 32'd1);
        step();
        glb_read_addr = 32'h80;
        samp();
        check("t6_gnt1", {31'h0, rd_gnt_o}, 32'd1);
        step();
        glb_read_addr = 32'h200;
        samp();
        check("t6_gnt2", {31'h0, rd_gnt_o}, 32'd1);
        step();
        glb_read_req = 1'b0;
        rst_n        = 1'b0;
        step();
        samp();
        check_reset_outputs("t6_rst");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            samp();
            check($sformatf("t6_no_valid[%0d]", i), {31'h0, rd_valid_o}, 32'd0);
        end
        check("sb_empty", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
